pipe_stall_flush_seq: RTL and testbench
=======================================

Name: pipe_stall_flush_seq

Overview:
- Sequences stall and flush control for the 5-stage pipelined datapath (IF/ID/EX/MEM/WB) that executes the SAD kernel.
- Converts single-cycle hazard requests into correctly timed multi-cycle bubble trains and flush pulses.
- Arbitrates between simultaneous load-use, RAW, branch and jump events.
- Keeps saturating stall and flush statistics readable by the testbench and debug logic.
- Sits between the hazard detection logic and the PC, IF/ID, ID/EX and EX/MEM pipeline registers.

Parameters:
- LOAD_STALL, 2, bubble cycles inserted for a load-use hazard (range 1..7).
- RAW_STALL, 3, bubble cycles inserted for a non-load RAW hazard with no forwarding (range 1..7).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- load_use_req  in  1  load-use hazard detected for the instruction in ID.
- raw_req  in  1  non-load RAW hazard detected for the instruction in ID.
- jump_id  in  1  jump decoded in ID.
- branch_taken_mem  in  1  branch resolved taken in MEM.
- stat_clr  in  1  synchronous clear of the statistics counters.
- pc_we  out  1  PC write enable, 1 = advance.
- ifid_we  out  1  IF/ID write enable, 1 = advance.
- idex_bubble  out  1  zero the ID/EX control fields this cycle.
- flush_ifid  out  1  clear IF/ID.
- flush_idex  out  1  clear ID/EX.
- flush_exmem  out  1  clear EX/MEM.
- busy  out  1  state is not RUN.
- stall_cycles  out  CNT_W  total cycles with pc_we=0, saturating.
- flush_events  out  CNT_W  total branch and jump flush events, saturating.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=RUN, remain=0, both counters=0.
  - Outputs: pc_we=1, ifid_we=1, all bubble and flush outputs=0, busy=0.
  - Reset asserted mid-stall aborts the stall immediately. First cycle after release is RUN.
- Control outputs are Mealy (combinational from state and inputs) so the stall covers the detection cycle. State, remain and counters are registered.
- States: RUN, STALL, FLUSH.
- Request priority: branch_taken_mem > load_use_req > raw_req > jump_id.
- RUN with branch_taken_mem:
  - flush_ifid=1, flush_idex=1, flush_exmem=0, pc_we=1 (target loads), ifid_we=1.
  - Next state FLUSH for 1 cycle; flush_events increments.
- RUN with load_use_req (no branch):
  - pc_we=0, ifid_we=0, idex_bubble=1.
  - Next state STALL with remain=LOAD_STALL-1. If LOAD_STALL=1, stay in RUN.
- RUN with raw_req: same as load_use_req, using RAW_STALL.
- RUN with jump_id only:
  - flush_ifid=1, pc_we=1, state stays RUN; flush_events increments.
- STALL:
  - pc_we=0, ifid_we=0, idex_bubble=1.
  - Each cycle remain decrements; at remain=1 the next state is RUN.
  - New hazard requests during STALL are ignored. The instruction in ID is held and re-detected after return to RUN.
  - branch_taken_mem in STALL overrides: flush outputs as in RUN, pc_we=1, remaining stall discarded, next state FLUSH.
- FLUSH:
  - Applies flush_ifid=1 and flush_idex=1 for one more cycle (squashes the wrong-path fetch), pc_we=1.
  - Next state RUN. Requests are ignored except branch_taken_mem, which re-enters FLUSH and counts again.
- stall_cycles increments every cycle pc_we=0. flush_events increments once per accepted branch or jump flush.
- Counters saturate at 2^CNT_W-1 and never wrap. stat_clr zeroes both; an increment in the same cycle is lost (clear wins).
- busy = (state != RUN).

Test Plan:
- Reset hold then release with no requests: pc_we=ifid_we=1 every cycle, all flushes 0, counters stay 0.
- load_use_req pulsed for 1 cycle, LOAD_STALL=2: pc_we=0 for exactly 2 cycles (detect cycle plus 1 STALL cycle), idex_bubble=1 in both, stall_cycles=2.
- raw_req held 1 cycle, then branch_taken_mem asserted in the 2nd stall cycle: stall aborts, flush_ifid=flush_idex=1 for 2 cycles, stall_cycles=2, flush_events=1, busy returns to 0.
- load_use_req, raw_req and jump_id asserted together in RUN: load-use wins, 2 bubble cycles, no jump flush that cycle, flush_events=0.
- CNT_W=4 with 20 single-cycle jump_id pulses: flush_events saturates at 15. stat_clr together with a jump gives flush_events=0.
- rst_n dropped asynchronously mid-STALL (between clock edges): outputs return immediately to pc_we=1 and flushes 0, state=RUN, counters=0.

Source files
------------

// File: rtl/pipe_stall_flush_seq.sv
// pipe_stall_flush_seq: turns single-cycle hazard requests into timed stall bubble trains
// and flush pulses for a 5-stage pipeline, with saturating stall/flush statistics.
module pipe_stall_flush_seq #(
    parameter int LOAD_STALL = 2,
    parameter int RAW_STALL  = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_req,
    input  logic             raw_req,
    input  logic             jump_id,
    input  logic             branch_taken_mem,
    input  logic             stat_clr,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_bubble,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);
    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    state_t     state, state_nx;
    logic [2:0] remain, remain_nx, hold;
    logic       flush_acc;

    assign hold = load_use_req ? 3'(LOAD_STALL - 1) : 3'(RAW_STALL - 1);

    // Outputs are Mealy so the detection cycle itself is already stalled or flushed.
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_bubble = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        state_nx    = RUN;
        remain_nx   = 3'd0;
        flush_acc   = 1'b0;
        if (branch_taken_mem) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            state_nx   = FLUSH;
            flush_acc  = 1'b1;
        end else if (state == STALL) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            state_nx    = remain == 3'd1 ? RUN : STALL;
            remain_nx   = remain - 3'd1;
        end else if (state == FLUSH) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (load_use_req || raw_req) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            state_nx    = hold == 3'd0 ? RUN : STALL;
            remain_nx   = hold;
        end else if (jump_id) begin
            flush_ifid = 1'b1;
            flush_acc  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            remain       <= 3'd0;
            busy         <= 1'b0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            state        <= state_nx;
            remain       <= remain_nx;
            busy         <= state_nx != RUN;
            stall_cycles <= stat_clr ? '0 :
                            (!pc_we && stall_cycles != '1) ? stall_cycles + CNT_W'(1) : stall_cycles;
            flush_events <= stat_clr ? '0 :
                            (flush_acc && flush_events != '1) ? flush_events + CNT_W'(1) : flush_events;
        end
    end
endmodule

// File: tb/tb_pipe_stall_flush_seq.sv
// tb_pipe_stall_flush_seq: directed plus random stimulus against a bubble-count reference model,
// driving a default instance and a CNT_W=4 instance from the same inputs.
module tb_pipe_stall_flush_seq;
    localparam int LS = 2;
    localparam int RS = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic load_use_req, raw_req, jump_id, branch_taken_mem, stat_clr;
    logic pc_we, ifid_we, idex_bubble, flush_ifid, flush_idex, flush_exmem, busy;
    logic s_pc_we, s_ifid_we, s_idex_bubble, s_flush_ifid, s_flush_idex, s_flush_exmem, s_busy;
    logic [15:0] stall_cycles, flush_events;
    logic [3:0]  s_stall_cycles, s_flush_events;

    int checks = 0;
    int failures = 0;
    int stall_left = 0;
    bit flush_next = 0;
    int sc = 0, fe = 0, sc4 = 0, fe4 = 0;

    always #5 clk = ~clk;

    pipe_stall_flush_seq #(.LOAD_STALL(LS), .RAW_STALL(RS), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .load_use_req(load_use_req), .raw_req(raw_req),
        .jump_id(jump_id), .branch_taken_mem(branch_taken_mem), .stat_clr(stat_clr),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_bubble(idex_bubble), .flush_ifid(flush_ifid),
        .flush_idex(flush_idex), .flush_exmem(flush_exmem), .busy(busy),
        .stall_cycles(stall_cycles), .flush_events(flush_events));

    pipe_stall_flush_seq #(.LOAD_STALL(LS), .RAW_STALL(RS), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .load_use_req(load_use_req), .raw_req(raw_req),
        .jump_id(jump_id), .branch_taken_mem(branch_taken_mem), .stat_clr(stat_clr),
        .pc_we(s_pc_we), .ifid_we(s_ifid_we), .idex_bubble(s_idex_bubble), .flush_ifid(s_flush_ifid),
        .flush_idex(s_flush_idex), .flush_exmem(s_flush_exmem), .busy(s_busy),
        .stall_cycles(s_stall_cycles), .flush_events(s_flush_events));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input logic [6:0] ctl);
        check("ctl", {25'd0, pc_we, ifid_we, idex_bubble, flush_ifid, flush_idex, flush_exmem, busy}, {25'd0, ctl});
        check("ctl_sat", {25'd0, s_pc_we, s_ifid_we, s_idex_bubble, s_flush_ifid, s_flush_idex,
                          s_flush_exmem, s_busy}, {25'd0, ctl});
        check("stall_cycles", {16'd0, stall_cycles}, sc);
        check("flush_events", {16'd0, flush_events}, fe);
        check("stall_cycles_w4", {28'd0, s_stall_cycles}, sc4);
        check("flush_events_w4", {28'd0, s_flush_events}, fe4);
    endtask

    // One clock of stimulus: the model decides this cycle's outputs from bubbles still owed
    // and whether a squash cycle is pending, then books the counters at the edge.
    task automatic step(input bit lu, input bit rw, input bit jp, input bit br, input bit clr);
        bit pc = 1, ifd = 1, bub = 0, fi = 0, fx = 0, facc = 0, bsy, nflush;
        int nstall;
        load_use_req = lu; raw_req = rw; jump_id = jp; branch_taken_mem = br; stat_clr = clr;
        bsy = stall_left > 0 || flush_next;
        nstall = stall_left;
        nflush = flush_next;
        if (br) begin
            fi = 1; fx = 1; nstall = 0; nflush = 1; facc = 1;
        end else if (stall_left > 0) begin
            pc = 0; ifd = 0; bub = 1; nstall = stall_left - 1;
        end else if (flush_next) begin
            fi = 1; fx = 1; nflush = 0;
        end else if (lu || rw) begin
            pc = 0; ifd = 0; bub = 1; nstall = (lu ? LS : RS) - 1;
        end else if (jp) begin
            fi = 1; facc = 1;
        end
        #3;
        check_all({pc, ifd, bub, fi, fx, 1'b0, bsy});
        @(posedge clk);
        stall_left = nstall;
        flush_next = nflush;
        if (clr) begin
            sc = 0; fe = 0; sc4 = 0; fe4 = 0;
        end else begin
            if (!pc) begin
                sc = sc < 65535 ? sc + 1 : sc;
                sc4 = sc4 < 15 ? sc4 + 1 : sc4;
            end
            if (facc) begin
                fe = fe < 65535 ? fe + 1 : fe;
                fe4 = fe4 < 15 ? fe4 + 1 : fe4;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 0;
        load_use_req = 0; raw_req = 0; jump_id = 0; branch_taken_mem = 0; stat_clr = 0;
        #12;
        check_all(7'b1100000);
        rst_n = 1;
        @(posedge clk);
        #1;
        idle(3);
        step(1, 0, 0, 0, 0);
        idle(3);
        check("load_use_stall_total", {16'd0, stall_cycles}, 32'd2);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        idle(3);
        check("raw_branch_flush_total", {16'd0, flush_events}, 32'd1);
        step(1, 1, 1, 0, 0);
        idle(3);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1, 0, 0);
            step(0, 0, 0, 0, 0);
        end
        check("flush_w4_saturated", {28'd0, s_flush_events}, 32'd15);
        step(0, 0, 1, 0, 1);
        idle(1);
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        idle(2);
        step(1, 0, 0, 0, 0);
        load_use_req = 0;
        #2;
        rst_n = 0;
        #1;
        stall_left = 0; flush_next = 0; sc = 0; fe = 0; sc4 = 0; fe4 = 0;
        check_all(7'b1100000);
        @(posedge clk);
        #1;
        rst_n = 1;
        idle(2);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
